// File: rtl/pkt_proc_enq_arbiter_if.sv
// Source-side and packet-processor-side signals of the enqueue arbiter.
// The arbiter uses the slave modport; the environment uses the master modport.
interface pkt_proc_enq_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 32,
    parameter int LW    = 12
);
    logic [N_REQ-1:0]    src_valid;
    logic [N_REQ-1:0]    src_sop;
    logic [N_REQ-1:0]    src_eop;
    logic [N_REQ*DW-1:0] src_data;
    logic [N_REQ*LW-1:0] src_len;
    logic [N_REQ-1:0]    src_ready;

    logic                enq_req;
    logic                in_sop;
    logic                in_eop;
    logic [DW-1:0]       wr_data_i;
    logic                pck_len_valid;
    logic [LW-1:0]       pck_len_i;
    logic                pck_proc_full;
    logic                pck_proc_almost_full;

    modport slave (
        input  src_valid, src_sop, src_eop, src_data, src_len,
        input  pck_proc_full, pck_proc_almost_full,
        output src_ready,
        output enq_req, in_sop, in_eop, wr_data_i, pck_len_valid, pck_len_i
    );

    modport master (
        output src_valid, src_sop, src_eop, src_data, src_len,
        output pck_proc_full, pck_proc_almost_full,
        input  src_ready,
        input  enq_req, in_sop, in_eop, wr_data_i, pck_len_valid, pck_len_i
    );
endinterface

// File: rtl/pkt_proc_enq_arbiter.sv
// Packet-atomic round-robin arbiter sharing the packet processor enqueue port.
// state | meaning
// IDLE  | pick next sop candidate from rr_ptr, or drop one stray beat
// XFER  | granted source owns the port until its eop beat is accepted
module pkt_proc_enq_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 32,
    parameter int LW    = 12
) (
    input  logic                 pck_proc_int_mem_fsm_clk,
    input  logic                 pck_proc_int_mem_fsm_rst,
    pkt_proc_enq_arbiter_if.slave bus,
    output logic [N_REQ-1:0]     grant,
    output logic                 len_err,
    output logic                 stray_drop
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;
    localparam logic [LW-1:0] CNT_MAX = '1;

    logic [0:0]       state;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    g_idx;
    logic [LW-1:0]    beat_cnt;
    logic [LW-1:0]    len_q;

    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] stray_sel;
    logic [N_REQ-1:0] ready;
    logic [PW-1:0]    win_idx;
    logic             win_found;
    logic             stray_found;
    int               idx;

    logic             accept;
    logic             stray_hit;
    logic             sop_beat;
    logic             g_eop;
    logic [DW-1:0]    g_data;
    logic [LW-1:0]    g_len;
    logic [LW-1:0]    cnt_next;
    logic [LW-1:0]    len_cmp;

    logic             enq_req_q;
    logic             in_sop_q;
    logic             in_eop_q;
    logic             pck_len_valid_q;
    logic [DW-1:0]    wr_data_q;
    logic [LW-1:0]    pck_len_q;

    assign cand = bus.src_valid & bus.src_sop;

    always_comb begin
        win_idx     = '0;
        win_found   = 1'b0;
        stray_sel   = '0;
        stray_found = 1'b0;
        idx         = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_idx   = PW'(idx);
            end
            if (!stray_found && bus.src_valid[k] && !bus.src_sop[k]) begin
                stray_found  = 1'b1;
                stray_sel[k] = 1'b1;
            end
        end
    end

    assign g_eop  = bus.src_eop[g_idx];
    assign g_data = bus.src_data[g_idx*DW +: DW];
    assign g_len  = bus.src_len[g_idx*LW +: LW];

    // Strays are only swallowed when no sop is waiting, so they never delay a packet.
    always_comb begin
        ready = '0;
        if (!pck_proc_int_mem_fsm_rst) begin
            if (state == ST_IDLE) begin
                if (cand == '0) ready = stray_sel;
            end else begin
                ready[g_idx] = bus.src_valid[g_idx] & ~bus.pck_proc_full;
            end
        end
    end

    assign bus.src_ready = ready;
    assign accept    = (state == ST_XFER) && ready[g_idx];
    assign stray_hit = (state == ST_IDLE) && (ready != '0);
    // A sop seen after the first beat is plain data.
    assign sop_beat  = bus.src_sop[g_idx] && (beat_cnt == '0);
    assign cnt_next  = (beat_cnt == CNT_MAX) ? CNT_MAX : beat_cnt + 1'b1;
    assign len_cmp   = sop_beat ? g_len : len_q;

    always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
        if (pck_proc_int_mem_fsm_rst) begin
            state           <= ST_IDLE;
            rr_ptr          <= '0;
            g_idx           <= '0;
            grant           <= '0;
            beat_cnt        <= '0;
            len_q           <= '0;
            enq_req_q       <= 1'b0;
            in_sop_q        <= 1'b0;
            in_eop_q        <= 1'b0;
            pck_len_valid_q <= 1'b0;
            wr_data_q       <= '0;
            pck_len_q       <= '0;
            len_err         <= 1'b0;
            stray_drop      <= 1'b0;
        end else begin
            enq_req_q       <= accept;
            in_sop_q        <= accept && sop_beat;
            in_eop_q        <= accept && g_eop;
            pck_len_valid_q <= accept && sop_beat;
            len_err         <= accept && g_eop && (cnt_next != len_cmp);
            stray_drop      <= stray_hit;
            if (accept) begin
                wr_data_q <= g_data;
                if (sop_beat) begin
                    pck_len_q <= g_len;
                    len_q     <= g_len;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (win_found && !bus.pck_proc_almost_full) begin
                        state    <= ST_XFER;
                        g_idx    <= win_idx;
                        grant    <= N_REQ'(1) << win_idx;
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    if (accept) beat_cnt <= cnt_next;
                    if (accept && g_eop) begin
                        state  <= ST_IDLE;
                        grant  <= '0;
                        rr_ptr <= (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.enq_req       = enq_req_q;
    assign bus.in_sop        = in_sop_q;
    assign bus.in_eop        = in_eop_q;
    assign bus.pck_len_valid = pck_len_valid_q;
    assign bus.wr_data_i     = wr_data_q;
    assign bus.pck_len_i     = pck_len_q;
endmodule

// File: tb/tb_pkt_proc_enq_arbiter.sv
// Directed bench: scripted sources, output beats collected and compared to hand-computed values.
module tb_pkt_proc_enq_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int LW = 12;

    typedef struct {
        logic [31:0] d;
        logic        s;
        logic        e;
        logic        lv;
        logic [11:0] l;
        int          cyc;
    } rec_t;

    logic clk;
    logic rst;
    logic [N-1:0] grant;
    logic len_err;
    logic stray_drop;

    pkt_proc_enq_arbiter_if #(.N_REQ(N), .DW(DW), .LW(LW)) bus ();

    pkt_proc_enq_arbiter #(.N_REQ(N), .DW(DW), .LW(LW)) dut (
        .pck_proc_int_mem_fsm_clk (clk),
        .pck_proc_int_mem_fsm_rst (rst),
        .bus                      (bus),
        .grant                    (grant),
        .len_err                  (len_err),
        .stray_drop               (stray_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_len_err = 0;
    int          n_stray = 0;
    rec_t        out_q[$];
    logic [3:0]  grant_q[$];

    bit          act[N];
    bit          nosop[N];
    int          nb[N];
    int          ptr[N];
    int          decl[N];
    logic [31:0] base[N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int s, input int n, input int len, input logic [31:0] b, input bit ns);
        nb[s]    = n;
        decl[s]  = len;
        base[s]  = b;
        nosop[s] = ns;
        ptr[s]   = 0;
        act[s]   = 1'b1;
    endtask

    task automatic drive();
        for (int s = 0; s < N; s++) begin
            bus.src_valid[s]          = act[s];
            bus.src_sop[s]            = !nosop[s] && (ptr[s] == 0);
            bus.src_eop[s]            = (ptr[s] == nb[s] - 1);
            bus.src_data[s*DW +: DW]  = base[s] + 32'(ptr[s]);
            bus.src_len[s*LW +: LW]   = LW'(decl[s]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_recs(input int n, input int budget);
        int i;
        i = 0;
        while (out_q.size() < n && i < budget) begin
            tick();
            i++;
        end
        chk("rec_count", 64'(out_q.size()), 64'(n));
    endtask

    // Source model and output monitor: the only process driving src_* signals.
    initial begin
        logic [N-1:0] acc;
        logic [N-1:0] prev_grant;
        prev_grant = '0;
        for (int s = 0; s < N; s++) begin
            act[s] = 1'b0; nosop[s] = 1'b0; nb[s] = 1; ptr[s] = 0; decl[s] = 0; base[s] = '0;
        end
        drive();
        forever begin
            @(posedge clk);
            acc = bus.src_ready & bus.src_valid;
            cyc++;
            #1;
            for (int s = 0; s < N; s++) begin
                if (acc[s]) begin
                    ptr[s]++;
                    if (ptr[s] >= nb[s]) act[s] = 1'b0;
                end
            end
            drive();
            if (bus.enq_req)
                out_q.push_back('{bus.wr_data_i, bus.in_sop, bus.in_eop, bus.pck_len_valid, bus.pck_len_i, cyc});
            if (len_err) begin
                n_len_err++;
                chk("len_err_on_eop", 64'(bus.in_eop), 64'd1);
            end
            if (stray_drop) begin
                n_stray++;
                chk("stray_no_enq", 64'(bus.enq_req), 64'd0);
            end
            if (grant != '0 && prev_grant == '0) grant_q.push_back(grant);
            prev_grant = grant;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.pck_proc_full        = 1'b0;
        bus.pck_proc_almost_full = 1'b0;
        #1;
        for (int s = 0; s < N; s++) load(s, 3, 3, 32'h100 * 32'(s + 1), 1'b0);

        // reset with every source valid
        repeat (3) tick();
        chk("rst_ready", 64'(bus.src_ready), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_outs", {bus.enq_req, bus.in_sop, bus.in_eop, bus.pck_len_valid, len_err, stray_drop,
                         bus.wr_data_i, bus.pck_len_i}, 64'd0);
        rst = 1'b0;
        tick();
        chk("first_grant", 64'(grant), 64'h1);

        // round robin over four 3-beat packets
        wait_recs(12, 80);
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 3; k++) begin
                if (p*3 + k < out_q.size()) begin
                    chk("rr_beat", {out_q[p*3+k].d, out_q[p*3+k].s, out_q[p*3+k].e, out_q[p*3+k].lv},
                        {32'h100 * 32'(p + 1) + 32'(k), k == 0, k == 2, k == 0});
                    if (k == 0) chk("rr_len", 64'(out_q[p*3].l), 64'd3);
                end
            end
            if (p > 0 && p*3 < out_q.size())
                chk("rr_gap", 64'(out_q[p*3].cyc - out_q[p*3-1].cyc), 64'd2);
        end
        chk("rr_grants", 64'(grant_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_q.size(); i++)
            chk("rr_grant_order", 64'(grant_q[i]), 64'(4'b0001 << i));
        chk("rr_no_len_err", 64'(n_len_err), 64'd0);
        repeat (2) tick();

        // rr_ptr back at 0: source 0 wins over 3; single-beat packets
        out_q.delete();
        grant_q.delete();
        load(0, 1, 1, 32'h300, 1'b0);
        load(3, 1, 1, 32'h400, 1'b0);
        wait_recs(2, 20);
        if (grant_q.size() >= 2) begin
            chk("wrap_grant0", 64'(grant_q[0]), 64'h1);
            chk("wrap_grant1", 64'(grant_q[1]), 64'h8);
        end
        if (out_q.size() >= 2) begin
            chk("single0", {out_q[0].d, out_q[0].s, out_q[0].e, out_q[0].lv}, {32'h300, 3'b111});
            chk("single1", {out_q[1].d, out_q[1].s, out_q[1].e, out_q[1].lv}, {32'h400, 3'b111});
        end
        chk("single_no_len_err", 64'(n_len_err), 64'd0);
        repeat (2) tick();

        // full stall mid-packet
        out_q.delete();
        load(2, 4, 4, 32'hA0, 1'b0);
        for (int i = 0; i < 20 && ptr[2] < 2; i++) tick();
        chk("stall_reached", 64'(ptr[2]), 64'd2);
        bus.pck_proc_full = 1'b1;
        #1;
        chk("stall_ready_a", 64'(bus.src_ready[2]), 64'd0);
        tick();
        chk("stall_ready_b", 64'(bus.src_ready[2]), 64'd0);
        tick();
        chk("stall_hold", 64'(ptr[2]), 64'd2);
        bus.pck_proc_full = 1'b0;
        wait_recs(4, 20);
        for (int k = 0; k < 4 && k < out_q.size(); k++)
            chk("stall_beat", {out_q[k].d, out_q[k].s, out_q[k].e}, {32'hA0 + 32'(k), k == 0, k == 3});
        repeat (2) tick();

        // almost-full holds off a new packet
        out_q.delete();
        bus.pck_proc_almost_full = 1'b1;
        load(1, 2, 2, 32'hC0, 1'b0);
        repeat (3) tick();
        chk("af_no_grant", 64'(grant), 64'd0);
        bus.pck_proc_almost_full = 1'b0;
        tick();
        chk("af_grant", 64'(grant), 64'h2);
        chk("af_accept_cycle", {bus.src_ready[1], bus.enq_req}, 64'b10);
        tick();
        chk("af_first_enq", {bus.enq_req, bus.in_sop, bus.wr_data_i}, {2'b11, 32'hC0});
        wait_recs(2, 20);
        repeat (2) tick();

        // declared length 5, eop on beat 3
        out_q.delete();
        n_len_err = 0;
        load(0, 3, 5, 32'hB0, 1'b0);
        wait_recs(3, 20);
        tick();
        chk("len_err_count", 64'(n_len_err), 64'd1);
        for (int k = 0; k < 3 && k < out_q.size(); k++)
            chk("len_beat", {out_q[k].d, out_q[k].e}, {32'hB0 + 32'(k), k == 2});
        if (out_q.size() > 0) chk("len_decl", 64'(out_q[0].l), 64'd5);
        out_q.delete();
        load(0, 2, 2, 32'hD0, 1'b0);
        wait_recs(2, 20);
        tick();
        chk("len_err_next_ok", 64'(n_len_err), 64'd1);
        if (out_q.size() > 1) chk("next_pkt_tail", {out_q[1].d, out_q[1].e}, {32'hD1, 1'b1});
        repeat (2) tick();

        // stray beat while idle
        out_q.delete();
        n_stray = 0;
        load(3, 1, 0, 32'hDEAD, 1'b1);
        tick();
        chk("stray_ready", 64'(bus.src_ready), 64'h8);
        tick();
        chk("stray_pulse", {stray_drop, bus.enq_req}, 64'b10);
        tick();
        chk("stray_once", {stray_drop, 32'(n_stray)}, 64'd1);
        chk("stray_no_out", 64'(out_q.size()), 64'd0);
        chk("stray_no_grant", 64'(grant), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
